// File: rtl/calc_pkg.sv
// Shared calculator definitions: opcodes, error codes and sequencer states.
// Imported by the keypad-entry front end and the calculation sequencer.
package calc_pkg;

  localparam logic [3:0] OP_ADD    = 4'hA;
  localparam logic [3:0] OP_SUB    = 4'hB;
  localparam logic [3:0] OP_MUL    = 4'hC;
  localparam logic [3:0] OP_DIV    = 4'hD;
  localparam logic [3:0] OP_MOD    = 4'hE;
  localparam logic [3:0] KEY_ENTER = 4'hF;

  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned RES_MAX_DEF = 9999;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_DIV0    = 2'd1,
    ERR_OVF     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  function automatic logic op_is_valid(
    input logic [3:0] op
  );
    return (op >= OP_ADD) && (op <= OP_MOD);
  endfunction

  function automatic logic op_needs_nz_b(
    input logic [3:0] op
  );
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/calc_rise_detect.sv
// Rising-edge detector for level strobes (entry finish, key strobes).
// Emits a one-cycle pulse on the cycle the input first goes high.
module calc_rise_detect (
  input  logic IN_clk,
  input  logic IN_reset,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  // remember last sampled level
  always_ff @(posedge IN_clk or negedge IN_reset) begin
    if (!IN_reset) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/calc_sequencer.sv
// Calculation sequencer: captures operands on entry completion, checks
// them, runs the shared ALU over req/ack and reports result or error.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  parameter int unsigned RES_MAX = RES_MAX_DEF
) (
  input  logic        IN_clk,
  input  logic        IN_reset,
  input  logic        IN_finish,
  input  logic [15:0] IN_SRC,
  input  logic [15:0] IN_DST,
  input  logic [3:0]  IN_ALU_OP,
  input  logic        IN_alu_ack,
  input  logic [15:0] IN_alu_result,
  input  logic        IN_alu_ovf,
  output logic        OUT_alu_req,
  output logic [15:0] OUT_alu_a,
  output logic [15:0] OUT_alu_b,
  output logic [3:0]  OUT_alu_op,
  output logic [15:0] OUT_result,
  output logic        OUT_valid,
  output logic [1:0]  OUT_err,
  output logic        OUT_busy,
  output logic [2:0]  OUT_state
);

  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [15:0] RES_LIM  = 16'(RES_MAX);

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] res_q, res_d;
  err_e        err_q, err_d;
  logic        start;

  calc_rise_detect u_rise (
    .IN_clk   (IN_clk),
    .IN_reset (IN_reset),
    .d_i      (IN_finish),
    .rise_o   (start)
  );

  // state and datapath registers
  always_ff @(posedge IN_clk or negedge IN_reset) begin
    if (!IN_reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // next-state: capture, check, handshake, finish
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = IN_SRC;
          b_d     = IN_DST;
          op_d    = IN_ALU_OP;
          err_d   = ERR_NONE;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!op_is_valid(op_q)) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_ERR;
        end else if (op_needs_nz_b(op_q)
                     && (b_q == '0)) begin
          err_d   = ERR_DIV0;
          state_d = ST_ERR;
        end else if ((op_q == OP_SUB)
                     && (a_q < b_q)) begin
          err_d   = ERR_OVF;
          state_d = ST_ERR;
        end else begin
          cnt_d   = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (IN_alu_ack) begin
          if (IN_alu_ovf
              || (IN_alu_result > RES_LIM)) begin
            err_d   = ERR_OVF;
            state_d = ST_ERR;
          end else begin
            res_d   = IN_alu_result;
            state_d = ST_DONE;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d   = ERR_TIMEOUT;
          state_d = ST_ERR;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign OUT_alu_req = (state_q == ST_REQ)
                     || (state_q == ST_WAIT);
  assign OUT_alu_a   = a_q;
  assign OUT_alu_b   = b_q;
  assign OUT_alu_op  = op_q;
  assign OUT_result  = res_q;
  assign OUT_valid   = (state_q == ST_DONE)
                     || (state_q == ST_ERR);
  assign OUT_err     = err_q;
  assign OUT_busy    = (state_q != ST_IDLE);
  assign OUT_state   = state_q;

endmodule
